// File: rtl/hdmi_island_scheduler_pkg.sv
// Shared types and constants for the HDMI data-island scheduler:
// FSM states, source indices, period lengths and the packet payload struct.
package hdmi_island_scheduler_pkg;

   localparam int unsigned N_SRC     = 4;
   localparam int unsigned HDR_W     = 24;
   localparam int unsigned SUB_W     = 224;
   localparam int unsigned PRE_LEN   = 8;
   localparam int unsigned GUARD_LEN = 2;
   localparam int unsigned PKT_LEN   = 32;

   localparam logic [1:0] SRC_ACR = 2'd0;
   localparam logic [1:0] SRC_AUD = 2'd1;
   localparam logic [1:0] SRC_AVI = 2'd2;
   localparam logic [1:0] SRC_AIF = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD_WAIT,
      ST_PREAMBLE,
      ST_GUARD_L,
      ST_PACKET,
      ST_GUARD_T
   } state_e;

   typedef struct packed {
      logic [HDR_W-1:0] hdr;
      logic [SUB_W-1:0] sub;
   } pkt_t;

   // Round-robin successor within sources 1..3 (ACR never takes part).
   function automatic logic [1:0] rr_inc(input logic [1:0] p);
      return (p == SRC_AIF) ? SRC_AUD : 2'(p + 2'd1);
   endfunction

endpackage

// File: rtl/hdmi_island_scheduler_arbiter.sv
// Combinational packet arbiter: ACR has strict priority, sources 1..3
// share round-robin starting at rr_ptr_i.
module hdmi_island_arbiter
   import hdmi_island_scheduler_pkg::*;
(
   input  logic [N_SRC-1:0] req_i,
   input  logic [1:0]       rr_ptr_i,
   output logic             valid_c_o,
   output logic [1:0]       winner_c_o,
   output logic [N_SRC-1:0] grant_c_o,
   output logic [1:0]       rr_next_c_o
);

   logic [1:0] cand;

   always_comb begin
      valid_c_o   = 1'b0;
      winner_c_o  = SRC_ACR;
      rr_next_c_o = rr_ptr_i;
      cand        = rr_ptr_i;
      if (req_i[SRC_ACR]) begin
         valid_c_o = 1'b1;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (!valid_c_o && req_i[cand]) begin
               valid_c_o   = 1'b1;
               winner_c_o  = cand;
               rr_next_c_o = rr_inc(cand);
            end
            cand = rr_inc(cand);
         end
      end
      grant_c_o = valid_c_o ? (N_SRC'(1) << winner_c_o) : '0;
   end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island scheduler: measures blanking length, sizes the island,
// sequences preamble/guard/packet periods and captures arbitrated packets.
module hdmi_island_scheduler
   import hdmi_island_scheduler_pkg::*;
#(
   parameter int unsigned MAX_PKTS = 2,
   parameter int unsigned LEAD     = 4
) (
   input  logic               i_pixclk,
   input  logic               i_reset_n,
   input  logic               i_blank,
   input  logic [N_SRC-1:0]   i_req,
   input  logic [HDR_W-1:0]   i_hdr0,
   input  logic [HDR_W-1:0]   i_hdr1,
   input  logic [HDR_W-1:0]   i_hdr2,
   input  logic [HDR_W-1:0]   i_hdr3,
   input  logic [SUB_W-1:0]   i_sub0,
   input  logic [SUB_W-1:0]   i_sub1,
   input  logic [SUB_W-1:0]   i_sub2,
   input  logic [SUB_W-1:0]   i_sub3,
   output logic [N_SRC-1:0]   o_ack,
   output logic               o_preamble,
   output logic               o_guard,
   output logic               o_data,
   output logic               o_first,
   output logic [4:0]         o_slot,
   output logic [1:0]         o_src,
   output logic [HDR_W-1:0]   o_hdr,
   output logic [SUB_W-1:0]   o_sub,
   output logic               o_abort
);

   localparam int unsigned LEN_W    = 12;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned NPK_W    = 5;
   localparam int unsigned SLOT_W   = 5;
   localparam int unsigned OVERHEAD = 24;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [SLOT_W-1:0]  slot_q;
   logic [NPK_W-1:0]   sent_q;
   logic [1:0]         rr_q;
   logic               blank_q;
   logic [LEN_W-1:0]   blank_cnt_q;
   logic [LEN_W-1:0]   len_prev_q;
   logic               pre_q, guard_q, data_q, first_q, abort_q;
   logic [N_SRC-1:0]   ack_q;
   logic [1:0]         src_q;
   pkt_t               pkt_q;

   logic [LEN_W-1:0]   avail_c;
   logic [6:0]         quot_c;
   logic [NPK_W-1:0]   n_c;
   logic [N_SRC-1:0]   req_eff_c;
   logic               arb_valid_c;
   logic [1:0]         arb_winner_c;
   logic [N_SRC-1:0]   arb_grant_c;
   logic [1:0]         arb_rr_next_c;
   pkt_t               pkt_sel_c;
   logic               rise_c;
   logic               launch_c;

   // Packets allowed in the coming island, from the previous blank length.
   always_comb begin
      avail_c = len_prev_q - LEN_W'(LEAD + OVERHEAD);
      quot_c  = 7'(avail_c >> 5);
      n_c     = '0;
      if (len_prev_q >= LEN_W'(LEAD + OVERHEAD + PKT_LEN))
         n_c = (quot_c > 7'(MAX_PKTS)) ? NPK_W'(MAX_PKTS) : NPK_W'(quot_c);
   end

   assign req_eff_c = i_req & ~ack_q;
   assign rise_c    = i_blank & ~blank_q;

   hdmi_island_arbiter u_arb (
      .req_i       (req_eff_c),
      .rr_ptr_i    (rr_q),
      .valid_c_o   (arb_valid_c),
      .winner_c_o  (arb_winner_c),
      .grant_c_o   (arb_grant_c),
      .rr_next_c_o (arb_rr_next_c)
   );

   always_comb begin
      case (arb_winner_c)
         SRC_ACR: pkt_sel_c = {i_hdr0, i_sub0};
         SRC_AUD: pkt_sel_c = {i_hdr1, i_sub1};
         SRC_AVI: pkt_sel_c = {i_hdr2, i_sub2};
         default: pkt_sel_c = {i_hdr3, i_sub3};
      endcase
   end

   assign launch_c = arb_valid_c &&
      ((state_q == ST_GUARD_L && cnt_q == CNT_W'(GUARD_LEN - 1)) ||
       (state_q == ST_PACKET && slot_q == SLOT_W'(PKT_LEN - 1) && sent_q < n_c));

   // Blank length measurement, latched on the blank falling edge.
   always_ff @(posedge i_pixclk) begin
      if (!i_reset_n) begin
         blank_q     <= 1'b0;
         blank_cnt_q <= '0;
         len_prev_q  <= '0;
      end else begin
         blank_q <= i_blank;
         if (i_blank) begin
            if (blank_cnt_q != '1) blank_cnt_q <= blank_cnt_q + LEN_W'(1);
         end else begin
            blank_cnt_q <= '0;
            if (blank_q) len_prev_q <= blank_cnt_q;
         end
      end
   end

   always_ff @(posedge i_pixclk) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         slot_q  <= '0;
         sent_q  <= '0;
         rr_q    <= SRC_AUD;
         pre_q   <= 1'b0;
         guard_q <= 1'b0;
         data_q  <= 1'b0;
         first_q <= 1'b0;
         abort_q <= 1'b0;
         ack_q   <= '0;
         src_q   <= '0;
         pkt_q   <= '0;
      end else begin
         ack_q   <= '0;
         first_q <= 1'b0;
         abort_q <= 1'b0;
         if (state_q != ST_IDLE && !i_blank) begin
            // Blank ended early: drop the island, clear every period output.
            state_q <= ST_IDLE;
            abort_q <= 1'b1;
            pre_q   <= 1'b0;
            guard_q <= 1'b0;
            data_q  <= 1'b0;
            cnt_q   <= '0;
            slot_q  <= '0;
            src_q   <= '0;
            pkt_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (rise_c && n_c != '0 && |i_req) begin
                     state_q <= ST_LEAD_WAIT;
                     cnt_q   <= '0;
                     sent_q  <= '0;
                  end
               end
               ST_LEAD_WAIT: begin
                  if (cnt_q == CNT_W'(LEAD - 1)) begin
                     state_q <= ST_PREAMBLE;
                     cnt_q   <= '0;
                     pre_q   <= 1'b1;
                  end else cnt_q <= cnt_q + CNT_W'(1);
               end
               ST_PREAMBLE: begin
                  if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
                     state_q <= ST_GUARD_L;
                     cnt_q   <= '0;
                     pre_q   <= 1'b0;
                     guard_q <= 1'b1;
                  end else cnt_q <= cnt_q + CNT_W'(1);
               end
               ST_GUARD_L: begin
                  if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                     cnt_q <= '0;
                     if (!arb_valid_c) state_q <= ST_GUARD_T;
                  end else cnt_q <= cnt_q + CNT_W'(1);
               end
               ST_PACKET: begin
                  if (slot_q == SLOT_W'(PKT_LEN - 1)) begin
                     slot_q <= '0;
                     if (!launch_c) begin
                        state_q <= ST_GUARD_T;
                        data_q  <= 1'b0;
                        guard_q <= 1'b1;
                     end
                  end else slot_q <= slot_q + SLOT_W'(1);
               end
               ST_GUARD_T: begin
                  if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                     guard_q <= 1'b0;
                  end else cnt_q <= cnt_q + CNT_W'(1);
               end
               default: state_q <= ST_IDLE;
            endcase
            // Packet start (after leading guard or back-to-back): grant and capture.
            if (launch_c) begin
               state_q <= ST_PACKET;
               guard_q <= 1'b0;
               data_q  <= 1'b1;
               first_q <= (state_q == ST_GUARD_L);
               slot_q  <= '0;
               ack_q   <= arb_grant_c;
               src_q   <= arb_winner_c;
               pkt_q   <= pkt_sel_c;
               rr_q    <= arb_rr_next_c;
               sent_q  <= sent_q + NPK_W'(1);
            end
         end
      end
   end

   assign o_ack      = ack_q;
   assign o_preamble = pre_q;
   assign o_guard    = guard_q;
   assign o_data     = data_q;
   assign o_first    = first_q;
   assign o_slot     = slot_q;
   assign o_src      = src_q;
   assign o_hdr      = pkt_q.hdr;
   assign o_sub      = pkt_q.sub;
   assign o_abort    = abort_q;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for hdmi_island_scheduler: per-cycle period timeline checks
// plus a scoreboard of expected grants popped whenever o_ack fires.
module tb_hdmi_island_scheduler;

   localparam int LEAD_T  = 4;
   localparam int PKT0_K  = LEAD_T + 8 + 2;

   typedef struct {
      logic [3:0]   ack;
      logic [1:0]   src;
      logic [23:0]  hdr;
      logic [223:0] sub;
   } exp_t;

   logic         clk;
   logic         i_reset_n;
   logic         i_blank;
   logic [3:0]   i_req;
   logic [23:0]  hdr [4];
   logic [223:0] sub [4];
   logic [3:0]   o_ack;
   logic         o_preamble, o_guard, o_data, o_first, o_abort;
   logic [4:0]   o_slot;
   logic [1:0]   o_src;
   logic [23:0]  o_hdr;
   logic [223:0] o_sub;

   exp_t         sb [$];
   int           n_cmp = 0;
   int           n_bad = 0;
   bit           drop_on_ack = 1'b1;
   logic [23:0]  last_hdr = '0;

   hdmi_island_scheduler #(.MAX_PKTS(2), .LEAD(LEAD_T)) dut (
      .i_pixclk   (clk),
      .i_reset_n  (i_reset_n),
      .i_blank    (i_blank),
      .i_req      (i_req),
      .i_hdr0     (hdr[0]),
      .i_hdr1     (hdr[1]),
      .i_hdr2     (hdr[2]),
      .i_hdr3     (hdr[3]),
      .i_sub0     (sub[0]),
      .i_sub1     (sub[1]),
      .i_sub2     (sub[2]),
      .i_sub3     (sub[3]),
      .o_ack      (o_ack),
      .o_preamble (o_preamble),
      .o_guard    (o_guard),
      .o_data     (o_data),
      .o_first    (o_first),
      .o_slot     (o_slot),
      .o_src      (o_src),
      .o_hdr      (o_hdr),
      .o_sub      (o_sub),
      .o_abort    (o_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int s);
      exp_t e;
      e.ack = 4'(1 << s);
      e.src = 2'(s);
      e.hdr = hdr[s];
      e.sub = sub[s];
      sb.push_back(e);
   endtask

   // One clock; any grant is matched against the scoreboard head.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (o_ack !== 4'b0000) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 256'(o_ack), 256'(0));
         end else begin
            e = sb.pop_front();
            check("ack", 256'(o_ack), 256'(e.ack));
            check("src", 256'(o_src), 256'(e.src));
            check("hdr", 256'(o_hdr), 256'(e.hdr));
            check("sub", 256'(o_sub), 256'(e.sub));
            last_hdr = e.hdr;
         end
         if (drop_on_ack) i_req = i_req & ~o_ack;
      end
   endtask

   // Expected period outputs k cycles after the blank rising edge.
   task automatic check_period(input int k, input int npk);
      int         pend;
      logic       pre, grd, dat, fst;
      logic [4:0] slot;
      pend = PKT0_K + 32 * npk;
      pre  = (npk > 0) && k >= LEAD_T && k < LEAD_T + 8;
      grd  = (npk > 0) && ((k >= LEAD_T + 8 && k < PKT0_K) || (k >= pend && k < pend + 2));
      dat  = (npk > 0) && k >= PKT0_K && k < pend;
      slot = dat ? 5'((k - PKT0_K) % 32) : 5'd0;
      fst  = dat && k == PKT0_K;
      check($sformatf("period_k%0d", k),
            256'({o_abort, o_preamble, o_guard, o_data, o_first, |o_ack, o_slot}),
            256'({1'b0, pre, grd, dat, fst, dat && slot == 5'd0, slot}));
      if (dat && slot == 5'd31) check("hdr_hold", 256'(o_hdr), 256'(last_hdr));
   endtask

   task automatic run_line(input int len, input int npk);
      i_blank = 1'b1;
      for (int k = 0; k < len; k++) begin
         tick();
         check_period(k, npk);
      end
      i_blank = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check("idle_gap", 256'({o_abort, o_preamble, o_guard, o_data, |o_ack}), 256'(0));
      end
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_blank   = 1'b0;
      i_req     = 4'b0000;
      for (int s = 0; s < 4; s++) begin
         hdr[s] = 24'($urandom);
         sub[s] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      for (int i = 0; i < 3; i++) tick();
      check("reset_ctl", 256'({o_ack, o_preamble, o_guard, o_data, o_first, o_slot, o_src, o_abort}), 256'(0));
      check("reset_hdr", 256'(o_hdr), 256'(0));
      check("reset_sub", 256'(o_sub), 256'(0));
      i_reset_n = 1'b1;
      gap(5);

      // No blank measured yet: no island; next line carries the ACR packet.
      i_req = 4'b0001;
      run_line(160, 0);
      gap(20);
      push_exp(0);
      run_line(160, 1);
      gap(20);

      // len 70 gives one packet: ACR wins, audio stays pending.
      run_line(70, 0);
      gap(20);
      i_req = 4'b0011;
      push_exp(0);
      run_line(59, 1);
      i_req = 4'b0000;
      gap(20);

      // len 59 is below threshold: no island despite a request.
      i_req = 4'b0010;
      run_line(60, 0);
      gap(20);

      // len 60 gives n=1; held requests rotate 1, 2, 3.
      drop_on_ack = 1'b0;
      i_req = 4'b1110;
      for (int s = 1; s <= 3; s++) begin
         push_exp(s);
         run_line(60, 1);
         gap(20);
      end
      drop_on_ack = 1'b1;
      i_req = 4'b0000;

      // Two back-to-back packets: ACR then audio, 32 cycles apart.
      run_line(160, 0);
      gap(20);
      i_req = 4'b0011;
      push_exp(0);
      push_exp(1);
      run_line(160, 2);
      gap(20);
      check("req_consumed", 256'(i_req), 256'(0));

      // Blank falls at packet slot 10.
      i_req = 4'b0001;
      push_exp(0);
      i_blank = 1'b1;
      for (int k = 0; k <= PKT0_K + 10; k++) begin
         tick();
         check_period(k, 2);
      end
      check("abort_slot", 256'(o_slot), 256'(10));
      i_blank = 1'b0;
      tick();
      check("abort_pulse", 256'({o_abort, o_preamble, o_guard, o_data, |o_ack, o_slot}), 256'(10'b10000_00000));
      tick();
      check("abort_after", 256'({o_abort, o_preamble, o_guard, o_data, o_first, o_ack, o_slot, o_src, o_hdr}), 256'(0));
      check("abort_after_sub", 256'(o_sub), 256'(0));
      gap(20);

      // Reset while in the leading guard band.
      i_req = 4'b0000;
      run_line(160, 0);
      gap(20);
      i_req = 4'b0001;
      i_blank = 1'b1;
      for (int k = 0; k <= LEAD_T + 8; k++) begin
         tick();
         check_period(k, 1);
      end
      i_reset_n = 1'b0;
      tick();
      check("rst_mid_ctl", 256'({o_abort, o_preamble, o_guard, o_data, o_first, o_ack, o_slot, o_src, o_hdr}), 256'(0));
      i_reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("rst_mid_quiet", 256'({o_abort, o_preamble, o_guard, o_data, |o_ack}), 256'(0));
      end
      i_blank = 1'b0;
      i_req = 4'b0000;
      gap(10);

      check("sb_empty", 256'(sb.size()), 256'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
